// File: rtl/drop_sequencer.sv
// drop_sequencer
//   Sequenced measure-and-drop controller. On start it captures the four
//   height sensors, averages the valid pair(s) into an 8-bit height, takes a
//   12-step restoring square root of height*2^16, halves it into t_fall,
//   compares the result against t_lim and either fires a timed drop pulse or
//   reports why the drop was refused.
// Ports
//   clk, rst                 : clock (rising edge), async active-high reset
//   start                    : measurement request, sampled in IDLE only
//   sensor1..sensor4 [7:0]   : raw heights, captured when start is accepted
//   t_lim [15:0]             : fall-time limit, sampled in DECIDE
//   drop_en                  : drop permission, sampled in DECIDE
//   busy                     : measurement/drop in progress
//   done                     : 1-cycle pulse when t_fall/decision update
//   t_fall [15:0]            : last fall time (held)
//   decision [1:0]           : 00 none, 01 COLD, 10 DROP, 11 ERR (held)
//   drop_activated           : drop command, DROP_CYCLES clocks long
module drop_sequencer #(
  parameter int DROP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  sensor1,
  input  logic [7:0]  sensor2,
  input  logic [7:0]  sensor3,
  input  logic [7:0]  sensor4,
  input  logic [15:0] t_lim,
  input  logic        drop_en,
  output logic        busy,
  output logic        done,
  output logic [15:0] t_fall,
  output logic [1:0]  decision,
  output logic        drop_activated
);

  localparam logic [1:0] DEC_COLD = 2'b01;
  localparam logic [1:0] DEC_DROP = 2'b10;
  localparam logic [1:0] DEC_ERR  = 2'b11;

  // HOLD is the completion cycle of the non-drop path: it keeps busy high
  // alongside done so both fall together and start is not taken early.
  typedef enum logic [2:0] {IDLE, LATCH, ROOT, DECIDE, DROP, HOLD} state_t;

  state_t      state, state_nxt;
  logic [7:0]  s1, s2, s3, s4;
  logic [7:0]  height;
  logic [23:0] rad_sr;
  logic [13:0] rem;
  logic [11:0] root;
  logic [3:0]  iter;
  logic [7:0]  drop_cnt;

  // pair / quad averages, 10-bit so the sums never overflow
  logic [9:0]  sum_24, sum_13, sum_all;
  logic [7:0]  height_nxt;

  always_comb begin
    sum_24  = {2'b0, s2} + {2'b0, s4} + 10'd1;
    sum_13  = {2'b0, s1} + {2'b0, s3} + 10'd1;
    sum_all = {2'b0, s1} + {2'b0, s2} + {2'b0, s3} + {2'b0, s4} + 10'd2;
    if (s1 == 8'd0 || s3 == 8'd0)      height_nxt = sum_24[8:1];
    else if (s2 == 8'd0 || s4 == 8'd0) height_nxt = sum_13[8:1];
    else                               height_nxt = sum_all[9:2];
  end

  // one restoring-sqrt step: bring down two radicand bits, try (root<<2)|1
  logic [15:0] rem_sh, trial;
  logic        fits;

  always_comb begin
    rem_sh = {rem, rad_sr[23:22]};
    trial  = {2'b0, root, 2'b01};
    fits   = (rem_sh >= trial);
  end

  logic [15:0] t_fall_nxt;
  logic [1:0]  dec_nxt;

  always_comb begin
    t_fall_nxt = {4'b0, root} >> 1;
    if (height == 8'd0)         dec_nxt = DEC_ERR;
    else if (t_fall_nxt > t_lim) dec_nxt = DEC_COLD;
    else if (!drop_en)          dec_nxt = DEC_ERR;
    else                        dec_nxt = DEC_DROP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LATCH;
      LATCH:   state_nxt = ROOT;
      ROOT:    if (iter == 4'd0) state_nxt = DECIDE;
      DECIDE:  state_nxt = (dec_nxt == DEC_DROP) ? DROP : HOLD;
      DROP:    if (drop_cnt == 8'd0) state_nxt = IDLE;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      s4       <= '0;
      height   <= '0;
      rad_sr   <= '0;
      rem      <= '0;
      root     <= '0;
      iter     <= '0;
      drop_cnt <= '0;
      done     <= 1'b0;
      t_fall   <= '0;
      decision <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          s1 <= sensor1;
          s2 <= sensor2;
          s3 <= sensor3;
          s4 <= sensor4;
        end
        LATCH: begin
          height <= height_nxt;
          rad_sr <= {height_nxt, 16'b0};
          rem    <= '0;
          root   <= '0;
          iter   <= 4'd11;
        end
        ROOT: begin
          rad_sr <= rad_sr << 2;
          iter   <= iter - 4'd1;
          if (fits) begin
            // remainder stays below 2*root+1, so 14 bits hold it
            rem  <= 14'(rem_sh - trial);
            root <= {root[10:0], 1'b1};
          end else begin
            rem  <= rem_sh[13:0];
            root <= {root[10:0], 1'b0};
          end
        end
        DECIDE: begin
          t_fall   <= t_fall_nxt;
          decision <= dec_nxt;
          done     <= 1'b1;
          drop_cnt <= 8'(DROP_CYCLES - 1);
        end
        DROP: if (drop_cnt != 8'd0) drop_cnt <= drop_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  // decoded straight from the state register, so reset clears them at once
  assign busy           = (state != IDLE);
  assign drop_activated = (state == DROP);

endmodule

// File: tb/tb_drop_sequencer.sv
module tb_drop_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  sensor1 = '0, sensor2 = '0, sensor3 = '0, sensor4 = '0;
  logic [15:0] t_lim = '0;
  logic        drop_en = 1'b0;
  logic        busy, done, drop_activated;
  logic [15:0] t_fall;
  logic [1:0]  decision;
  logic        busy1, done1, drop1;
  logic [15:0] t_fall1;
  logic [1:0]  decision1;

  always #5 clk = ~clk;

  drop_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3), .sensor4(sensor4),
    .t_lim(t_lim), .drop_en(drop_en),
    .busy(busy), .done(done), .t_fall(t_fall), .decision(decision),
    .drop_activated(drop_activated)
  );

  drop_sequencer #(.DROP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3), .sensor4(sensor4),
    .t_lim(t_lim), .drop_en(drop_en),
    .busy(busy1), .done(done1), .t_fall(t_fall1), .decision(decision1),
    .drop_activated(drop1)
  );

  typedef struct packed {
    logic [15:0] t;
    logic [1:0]  d;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference: pair selection, brute-force floor sqrt, decision priority
  function automatic exp_t model(input int a, input int b, input int c, input int d,
                                 input int tl, input bit den);
    int h, r;
    exp_t e;
    if (a == 0 || c == 0)      h = (b + d + 1) / 2;
    else if (b == 0 || d == 0) h = (a + c + 1) / 2;
    else                       h = (a + b + c + d + 2) / 4;
    r = 0;
    while ((r + 1) * (r + 1) <= h * 65536) r++;
    e.t = 16'(r / 2);
    if (h == 0)           e.d = 2'd3;
    else if (r / 2 > tl)  e.d = 2'd1;
    else if (!den)        e.d = 2'd3;
    else                  e.d = 2'd2;
    return e;
  endfunction

  // scoreboard: every done pops one expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_done: observed done with queue size %0d expected nonzero", q.size());
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_t_fall", t_fall, e.t);
        chk("sb_decision", decision, e.d);
      end
    end
  end

  task automatic start_meas();
    @(negedge clk);
    start = 1'b1;
    q.push_back(model(sensor1, sensor2, sensor3, sensor4, t_lim, drop_en));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // n = number of negedges after the accepting edge up to and including done
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    chk("done_seen", done, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_t_fall"}, t_fall, 0);
    chk({tag, "_decision"}, decision, 0);
    chk({tag, "_drop"}, drop_activated, 0);
  endtask

  task automatic set_sensors(input int a, input int b, input int c, input int d);
    sensor1 = 8'(a); sensor2 = 8'(b); sensor3 = 8'(c); sensor4 = 8'(d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, m, dc;

    // reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // nominal drop: 100s, t_lim at the boundary
    set_sensors(100, 100, 100, 100); t_lim = 16'd1280; drop_en = 1'b1;
    start_meas();
    wait_done(n);
    chk("drop_latency", n, 15);
    chk("drop_t_fall", t_fall, 1280);
    chk("drop_at_done", drop_activated, 1);
    chk("busy_at_done", busy, 1);
    chk("d1_done", done1, 1);
    chk("d1_drop_at_done", drop1, 1);
    m = 1;
    @(negedge clk);
    chk("d1_drop_1cycle", drop1, 0);
    chk("d1_idle_next", busy1, 0);
    while (drop_activated && m < 50) begin
      m++;
      @(negedge clk);
    end
    chk("drop_len", m, 4);
    chk("busy_falls_with_drop", busy, 0);

    // COLD: limit one below
    t_lim = 16'd1279;
    start_meas();
    wait_done(n);
    chk("cold_latency", n, 15);
    chk("cold_decision", decision, 1);
    chk("cold_no_drop", drop_activated, 0);
    @(negedge clk);
    chk("cold_busy_low", busy, 0);
    chk("cold_done_low", done, 0);

    // s1 invalid -> s2/s4 pair, then full scale
    set_sensors(0, 50, 200, 51); t_lim = 16'hFFFF;
    start_meas();
    wait_done(n);
    chk("pair_t_fall", t_fall, 914);
    chk("pair_drop", drop_activated, 1);
    wait_idle();
    set_sensors(255, 255, 255, 255);
    start_meas();
    wait_done(n);
    chk("max_t_fall", t_fall, 2043);
    wait_idle();

    // zero height; sensors change after capture
    set_sensors(0, 0, 0, 0);
    start_meas();
    set_sensors(100, 100, 100, 100);
    wait_done(n);
    chk("zero_err", decision, 3);
    chk("zero_no_drop", drop_activated, 0);
    wait_idle();

    // drop_en low, with start pulses during busy
    drop_en = 1'b0;
    dc = done_cnt;
    start_meas();
    for (int k = 0; k < 3; k++) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_done(n);
    chk("noen_err", decision, 3);
    chk("noen_no_drop", drop_activated, 0);
    wait_idle();
    repeat (20) @(negedge clk);
    chk("one_done_per_start", done_cnt - dc, 1);
    chk("ignored_starts_idle", busy, 0);

    // reset at ROOT iteration 6
    drop_en = 1'b1;
    set_sensors(30, 40, 50, 60);
    start_meas();
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    @(negedge clk);
    check_reset_outputs("rst_root");
    @(negedge clk) rst = 1'b0;
    start_meas();
    wait_done(n);
    chk("after_rst_t_fall", t_fall, 858);
    chk("after_rst_decision", decision, 2);
    wait_idle();

    // reset during DROP
    set_sensors(100, 100, 100, 100); t_lim = 16'd1280;
    start_meas();
    wait_done(n);
    @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    @(negedge clk);
    check_reset_outputs("rst_drop");
    @(negedge clk) rst = 1'b0;
    set_sensors(255, 255, 255, 255); t_lim = 16'hFFFF;
    start_meas();
    wait_done(n);
    chk("after_rst2_t_fall", t_fall, 2043);
    chk("after_rst2_decision", decision, 2);
    wait_idle();

    repeat (2) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
